tr_step_gen: RTL and testbench

Stepper-motor pulse generator for the tuner drive (TR). It receives the enable, direction and period commands produced by the automatic tuner-positioning controller and turns them into a physical STEP/DIR pulse train for the motor driver. It enforces direction setup time, minimum step spacing and a fixed step-pulse width. It also keeps a signed step-position counter for diagnostics.

---
 rtl/tr_pkg.sv | 21 ++
 rtl/tr_cycle_timer.sv | 33 +++
 rtl/tr_step_gen.sv | 116 +++++++++++
 tb/tb_tr_step_gen.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared FSM/direction types and 50 MHz timing defaults for the tuner-drive
// STEP/DIR pulse generator.
package tr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } tr_state_e;

  typedef enum logic {
    REV = 1'b0,
    FWD = 1'b1
  } tr_dir_t;

  localparam int unsigned TR_PULSE_W    = 50;
  localparam int unsigned TR_DIR_SETUP  = 250;
  localparam int unsigned TR_MIN_PERIOD = 100;

endpackage

// File: rtl/tr_cycle_timer.sv
// Loadable down-counter; loading N-1 raises expired_o for one cycle exactly
// N cycles after the load edge, so the owner can change state on the Nth edge.
module tr_cycle_timer
  import tr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/tr_step_gen.sv
// STEP/DIR pulse generator for the tuner stepper drive, with clamped period
// shadowing, direction setup time and a signed step-position counter.
//
// state    | meaning
// ST_IDLE  | stopped, step low, waiting for enable and a nonzero period
// ST_SETUP | dir_out just changed, holding DIR_SETUP cycles before a step
// ST_HIGH  | step high for PULSE_W cycles, cannot be interrupted
// ST_LOW   | step low for the rest of the active period
module tr_step_gen
  import tr_pkg::*;
#(
  parameter int unsigned WIDTH_PER  = 32,
  parameter int unsigned PULSE_W    = TR_PULSE_W,
  parameter int unsigned DIR_SETUP  = TR_DIR_SETUP,
  parameter int unsigned MIN_PERIOD = TR_MIN_PERIOD
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 dir_i,
  input  logic [WIDTH_PER-1:0] period_i,
  input  logic                 period_valid_i,
  input  logic                 cnt_clr_i,
  output logic                 step_o,
  output logic                 dir_out_o,
  output logic                 busy_o,
  output logic                 period_err_o,
  output logic [31:0]          step_count_o
);

  tr_state_e            state_q;
  logic [WIDTH_PER-1:0] per_sh_q, per_act_q;
  logic                 step_q, dir_out_q, busy_q, period_err_q;
  logic [31:0]          step_count_q;

  logic [WIDTH_PER-1:0] per_in, per_eff, tmr_val;
  logic per_clamp, run_ok, low_end, boundary;
  logic go_setup, go_high, go_low, go_idle, act_load, tmr_load, tmr_exp;

  // A strobe landing on a step boundary bypasses the shadow register.
  always_comb begin
    per_clamp = (period_i != '0) && (period_i < WIDTH_PER'(MIN_PERIOD));
    per_in    = per_clamp ? WIDTH_PER'(MIN_PERIOD) : period_i;
    per_eff   = period_valid_i ? per_in : per_sh_q;
    run_ok    = enable_i && (per_eff != '0);
    low_end   = (state_q == ST_LOW) && tmr_exp;
    boundary  = (state_q == ST_IDLE) || low_end;
    go_setup  = boundary && run_ok && (dir_i != dir_out_q);
    go_high   = (boundary && run_ok && (dir_i == dir_out_q))
              || ((state_q == ST_SETUP) && enable_i && tmr_exp);
    go_low    = (state_q == ST_HIGH) && tmr_exp;
    go_idle   = (low_end && !run_ok) || ((state_q == ST_SETUP) && !enable_i);
    act_load  = low_end || ((state_q == ST_IDLE) && run_ok);
    tmr_load  = go_setup || go_high || go_low;
    tmr_val   = '0;
    if (go_setup)     tmr_val = WIDTH_PER'(DIR_SETUP - 1);
    else if (go_high) tmr_val = WIDTH_PER'(PULSE_W - 1);
    else if (go_low)  tmr_val = per_act_q - WIDTH_PER'(PULSE_W + 1);
  end

  tr_cycle_timer #(.WIDTH(WIDTH_PER)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      per_sh_q     <= '0;
      per_act_q    <= '0;
      step_q       <= 1'b0;
      dir_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      period_err_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      if (period_valid_i) begin
        per_sh_q <= per_in;
        if (per_clamp) period_err_q <= 1'b1;
      end
      if (act_load) per_act_q <= per_eff;

      if (go_setup) begin
        state_q   <= ST_SETUP;
        dir_out_q <= dir_i;
        step_q    <= 1'b0;
        busy_q    <= 1'b1;
      end else if (go_high) begin
        state_q <= ST_HIGH;
        step_q  <= 1'b1;
        busy_q  <= 1'b1;
      end else if (go_low) begin
        state_q <= ST_LOW;
        step_q  <= 1'b0;
      end else if (go_idle) begin
        state_q <= ST_IDLE;
        step_q  <= 1'b0;
        busy_q  <= 1'b0;
      end

      if (cnt_clr_i)    step_count_q <= '0;
      else if (go_high) step_count_q <= (tr_dir_t'(dir_out_q) == FWD) ? step_count_q + 32'd1
                                                                     : step_count_q - 32'd1;
    end
  end

  assign step_o       = step_q;
  assign dir_out_o    = dir_out_q;
  assign busy_o       = busy_q;
  assign period_err_o = period_err_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_tr_step_gen.sv
// Self-checking bench for tr_step_gen: vector table, hand-written corner
// sequences, and a random run checked against an event-level step model.
module tb_tr_step_gen;

  localparam int PW   = 50;
  localparam int DS   = 250;
  localparam int MINP = 100;
  localparam int NR   = 20000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, dir = 1'b0, pv = 1'b0, clr = 1'b0;
  logic [31:0] per = '0;
  logic        step, dout, busy, perr;
  logic [31:0] cnt;

  int   total = 0, bad = 0, cyc = 0, rises = 0, hi_len = 0;
  logic prev_step = 1'b0, prev_s = 1'b0, prev_d = 1'b0;

  typedef struct {
    int unsigned per;
    bit          dir;
    int          lat;
    int          spc;
    bit          err;
  } vec_t;
  vec_t vecs[7];

  bit          en_a[NR], dir_a[NR], pv_a[NR];
  int unsigned per_a[NR], shv[NR];
  int          obs_q[$], exp_q[$];

  tr_step_gen dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (en),
    .dir_i          (dir),
    .period_i       (per),
    .period_valid_i (pv),
    .cnt_clr_i      (clr),
    .step_o         (step),
    .dir_out_o      (dout),
    .busy_o         (busy),
    .period_err_o   (perr),
    .step_count_o   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    prev_step = step;
    @(posedge clk);
    #1;
    cyc++;
    if (step && !prev_step) rises++;
  endtask

  task automatic tick_n(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_rise(input string nm, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (step && !prev_step) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=no_rise required=rise_within_%0d", nm, limit);
    end
  endtask

  task automatic wait_idle(input string nm, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (!busy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=busy required=idle_within_%0d", nm, limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pv = 1'b0; clr = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_step"}, step, 0);
    chk({nm, "_dir_out"}, dout, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, perr, 0);
    chk({nm, "_count"}, cnt, 0);
  endtask

  // Pulse width and "dir_out never moves while step is high" watched continuously.
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_len = 0;
      prev_s = 1'b0;
      prev_d = dout;
    end else begin
      if (dout !== prev_d) begin
        total++;
        if (step) begin
          bad++;
          $display("FAIL dir_during_step actual=step_%0d required=step_0", step);
        end
      end
      if (step) hi_len++;
      else if (prev_s) begin
        chk("pulse_width", hi_len, PW);
        hi_len = 0;
      end
      prev_s = step;
      prev_d = dout;
    end
  end

  function automatic int unsigned clampf(int unsigned p);
    return (p != 0 && p < MINP) ? MINP : p;
  endfunction

  function automatic int unsigned eff(int n);
    return pv_a[n] ? clampf(per_a[n]) : shv[n];
  endfunction

  // Event-level model: jumps from step boundary to step boundary.
  task automatic run_model(output logic [31:0] mcnt, output bit mdout, output bit merr);
    int unsigned sh, act;
    int n, b, r, m;
    bit done, running, aborted;
    sh = 0; n = 0; done = 0;
    mcnt = '0; mdout = 0; merr = 0;
    for (int k = 0; k < NR; k++) begin
      shv[k] = sh;
      if (pv_a[k]) begin
        sh = clampf(per_a[k]);
        if (per_a[k] != 0 && per_a[k] < MINP) merr = 1;
      end
    end
    while (!done) begin
      while (n < NR && !(en_a[n] && eff(n) != 0)) n++;
      if (n >= NR) break;
      b = n; act = eff(b); running = 1;
      while (running) begin
        r = b;
        if (dir_a[b] != mdout) begin
          mdout = dir_a[b];
          r = b + DS;
          aborted = 0;
          for (m = b + 1; m <= r && m < NR; m++) begin
            if (!en_a[m]) begin
              aborted = 1;
              break;
            end
          end
          if (aborted) begin
            n = m + 1;
            running = 0;
            continue;
          end
        end
        if (r >= NR) begin
          done = 1;
          running = 0;
          continue;
        end
        exp_q.push_back(r);
        mcnt = mdout ? mcnt + 32'd1 : mcnt - 32'd1;
        b = r + int'(act);
        if (b >= NR) begin
          done = 1;
          running = 0;
        end else if (!en_a[b] || eff(b) == 0) begin
          n = b + 1;
          running = 0;
        end else begin
          act = eff(b);
        end
      end
    end
  endtask

  initial begin
    int r, r2, c0, t, prev, c, nb;
    logic [31:0] mcnt;
    bit mdout, merr, e, d;

    vecs[0] = '{per: 1000, dir: 1, lat: 1 + DS, spc: 1000, err: 0};
    vecs[1] = '{per: 20,   dir: 0, lat: 1,      spc: 100,  err: 1};
    vecs[2] = '{per: 99,   dir: 1, lat: 1 + DS, spc: 100,  err: 1};
    vecs[3] = '{per: 100,  dir: 0, lat: 1,      spc: 100,  err: 0};
    vecs[4] = '{per: 101,  dir: 0, lat: 1,      spc: 101,  err: 0};
    vecs[5] = '{per: 0,    dir: 1, lat: 0,      spc: 0,    err: 0};
    vecs[6] = '{per: 450,  dir: 0, lat: 1,      spc: 450,  err: 0};

    tick_n(3);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_reset();
      chk_reset("vec_reset");
      dir = vecs[i].dir; per = vecs[i].per; pv = 1'b1;
      tick();
      pv = 1'b0;
      chk("vec_err", perr, vecs[i].err);
      c0 = cyc + 1;
      en = 1'b1;
      if (vecs[i].lat == 0) begin
        tick_n(600);
        chk("vec_stop_busy", busy, 0);
        chk("vec_stop_count", cnt, 0);
      end else begin
        wait_rise("vec_first", DS + 20, r);
        chk("vec_latency", r - c0 + 1, vecs[i].lat);
        wait_rise("vec_second", 1100, r2);
        chk("vec_spacing", r2 - r, vecs[i].spc);
        chk("vec_count", cnt, vecs[i].dir ? 32'd2 : 32'hFFFF_FFFE);
        per = 1000; pv = 1'b1;
        tick();
        pv = 1'b0;
        chk("vec_err_sticky", perr, vecs[i].err);
        en = 1'b0;
        wait_idle("vec_idle", 1200, t);
      end
    end

    // Steady forward run, reversal, mid-period update and boundary bypass.
    do_reset();
    dir = 1'b1; per = 1000; pv = 1'b1;
    tick();
    pv = 1'b0;
    c0 = cyc + 1;
    en = 1'b1;
    wait_rise("steady_first", 400, r);
    chk("steady_latency", r - c0 + 1, 1 + DS);
    prev = r;
    for (int i = 2; i <= 10; i++) begin
      wait_rise("steady_next", 1100, r);
      chk("steady_spacing", r - prev, 1000);
      prev = r;
    end
    chk("steady_count", cnt, 10);
    chk("steady_dir_out", dout, 1);
    dir = 1'b0;
    wait_rise("rev_rise", 1400, r);
    chk("rev_spacing", r - prev, 1000 + DS);
    chk("rev_count", cnt, 9);
    chk("rev_dir_out", dout, 0);
    prev = r;
    wait_rise("rev_next", 1100, r);
    chk("rev_next_spacing", r - prev, 1000);
    chk("rev_next_count", cnt, 8);
    prev = r;
    tick_n(500);
    per = 2000; pv = 1'b1;
    tick();
    pv = 1'b0;
    wait_rise("mid_a", 1100, r);
    chk("mid_keep_spacing", r - prev, 1000);
    prev = r;
    wait_rise("mid_b", 2100, r);
    chk("mid_new_spacing", r - prev, 2000);
    prev = r;
    tick_n(1999);
    per = 700; pv = 1'b1;
    tick();
    pv = 1'b0;
    chk("bypass_rise", step && !prev_step, 1);
    chk("bypass_spacing", cyc - prev, 2000);
    prev = cyc;
    wait_rise("bypass_next", 800, r);
    chk("bypass_new_spacing", r - prev, 700);
    prev = r;

    // Disable during HIGH: pulse and LOW complete, then idle with no edges.
    tick_n(10);
    en = 1'b0;
    wait_idle("dis_idle", 800, t);
    chk("dis_idle_time", t - prev, 700);
    c = rises;
    tick_n(1000);
    chk("dis_no_edges", rises, c);
    chk("dis_busy", busy, 0);

    // Period 0 during HIGH with enable held.
    c0 = cyc + 1;
    en = 1'b1;
    wait_rise("zero_start", 10, r);
    chk("zero_latency", r - c0 + 1, 1);
    prev = r;
    tick_n(5);
    per = 0; pv = 1'b1;
    tick();
    pv = 1'b0;
    wait_idle("zero_idle", 800, t);
    chk("zero_idle_time", t - prev, 700);
    c = rises;
    tick_n(800);
    chk("zero_no_edges", rises, c);
    chk("zero_busy", busy, 0);

    // cnt_clr coincident with a rise, then reverse wrap below zero.
    do_reset();
    dir = 1'b0; per = 300; pv = 1'b1;
    tick();
    pv = 1'b0;
    en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_rise", step, 1);
    chk("clr_count", cnt, 0);
    wait_rise("wrap_rise", 400, r);
    chk("wrap_count", cnt, 32'hFFFF_FFFF);
    en = 1'b0;
    wait_idle("wrap_idle", 400, t);

    // Reset in the middle of a forward pulse.
    do_reset();
    dir = 1'b1; per = 20; pv = 1'b1;
    tick();
    per = 300;
    tick();
    pv = 1'b0;
    en = 1'b1;
    wait_rise("rst_rise", 400, r);
    chk("rst_pre_dir_out", dout, 1);
    chk("rst_pre_err", perr, 1);
    tick_n(10);
    chk("rst_pre_step", step, 1);
    rst_n = 1'b0;
    tick();
    chk_reset("rst_mid_high");
    tick();
    rst_n = 1'b1;
    en = 1'b0;

    // Random run against the event-level model.
    e = 1; d = 0;
    for (int k = 0; k < NR; k++) begin
      if ($urandom_range(0, 1499) == 0) e = !e;
      if ($urandom_range(0, 899) == 0) d = !d;
      en_a[k] = e;
      dir_a[k] = d;
      pv_a[k] = (k == 3) || ($urandom_range(0, 349) == 0);
      if (k == 3) per_a[k] = 300;
      else if (pv_a[k]) begin
        case ($urandom_range(0, 9))
          0:       per_a[k] = 0;
          1:       per_a[k] = $urandom_range(1, MINP - 1);
          default: per_a[k] = $urandom_range(MINP, 600);
        endcase
      end else per_a[k] = $urandom_range(0, 5000);
    end
    do_reset();
    for (int k = 0; k < NR; k++) begin
      en = en_a[k]; dir = dir_a[k]; pv = pv_a[k]; per = per_a[k];
      tick();
      if (step && !prev_step) obs_q.push_back(k);
    end
    pv = 1'b0; en = 1'b0;
    run_model(mcnt, mdout, merr);
    chk("rand_rise_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      nb = bad;
      chk("rand_rise_time", obs_q[i], exp_q[i]);
      if (bad != nb) break;
    end
    chk("rand_count", cnt, mcnt);
    chk("rand_dir_out", dout, mdout);
    chk("rand_err", perr, merr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
